// File: rtl/byte_packer_if.sv
// rtl/byte_packer_if.sv - byte stream in / padder word out bundle for byte_packer
// slave is the packer's view; master is the UART-side and padder-side environment.
interface byte_packer_if;
   logic [7:0]  in_byte;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [31:0] pad_in;
   logic        pad_in_ready;
   logic        pad_is_last;
   logic [1:0]  pad_byte_num;
   logic        pad_buffer_full;
   logic        msg_done;

   modport slave (
      input  in_byte,
      input  in_valid,
      input  in_last,
      input  pad_buffer_full,
      output in_ready,
      output pad_in,
      output pad_in_ready,
      output pad_is_last,
      output pad_byte_num,
      output msg_done
   );

   modport master (
      output in_byte,
      output in_valid,
      output in_last,
      output pad_buffer_full,
      input  in_ready,
      input  pad_in,
      input  pad_in_ready,
      input  pad_is_last,
      input  pad_byte_num,
      input  msg_done
   );
endinterface

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - packs a byte stream MSB-first into 32-bit words for the Keccak padder
// Accumulator fills a word, a one-word hold register presents it; one message per reset.
module byte_packer (
   input  logic          clk,
   input  logic          rst_n,
   byte_packer_if.slave  bus
);

   typedef enum logic {
      FILL = 1'b0,
      DONE = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] acc_q, acc_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        acc_last_q, acc_last_d;
   logic [31:0] hold_q, hold_d;
   logic        hold_valid_q, hold_valid_d;
   logic        hold_last_q, hold_last_d;
   logic [1:0]  hold_bn_q, hold_bn_d;
   logic        msg_done_q, msg_done_d;

   logic in_ready;
   logic accept;
   logic handoff;
   logic transfer;

   // Derived only from registers, so no combinational path from in_valid or buffer_full.
   assign in_ready = (state_q == FILL) && (cnt_q < 3'd4) && !acc_last_q;
   assign accept   = bus.in_valid && in_ready;
   assign handoff  = hold_valid_q && !bus.pad_buffer_full && (state_q == FILL);
   assign transfer = (state_q == FILL) && !hold_valid_q && ((cnt_q == 3'd4) || acc_last_q);

   assign bus.in_ready     = in_ready;
   assign bus.pad_in       = hold_q;
   assign bus.pad_in_ready = handoff;
   // The padder latches is_last unconditionally, so it must share the buffer_full gating.
   assign bus.pad_is_last  = handoff && hold_last_q;
   assign bus.pad_byte_num = hold_last_q ? hold_bn_q : 2'd0;
   assign bus.msg_done     = msg_done_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= FILL;
         acc_q        <= '0;
         cnt_q        <= '0;
         acc_last_q   <= 1'b0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         hold_last_q  <= 1'b0;
         hold_bn_q    <= '0;
         msg_done_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         acc_last_q   <= acc_last_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         hold_last_q  <= hold_last_d;
         hold_bn_q    <= hold_bn_d;
         msg_done_q   <= msg_done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      acc_last_d   = acc_last_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      hold_last_d  = hold_last_q;
      hold_bn_d    = hold_bn_q;
      msg_done_d   = msg_done_q;

      if (accept) begin
         case (cnt_q[1:0])
            2'd0:    acc_d[31:24] = bus.in_byte;
            2'd1:    acc_d[23:16] = bus.in_byte;
            2'd2:    acc_d[15:8]  = bus.in_byte;
            default: acc_d[7:0]   = bus.in_byte;
         endcase
         cnt_d      = cnt_q + 3'd1;
         acc_last_d = bus.in_last;
      end

      if (handoff) begin
         hold_valid_d = 1'b0;
         if (hold_last_q) begin
            state_d    = DONE;
            msg_done_d = 1'b1;
         end
      end

      // acc_last survives a full-word transfer so that an empty last word follows it.
      if (transfer) begin
         hold_d       = acc_q;
         hold_valid_d = 1'b1;
         acc_d        = '0;
         cnt_d        = '0;
         if (cnt_q == 3'd4) begin
            hold_last_d = 1'b0;
            hold_bn_d   = 2'd0;
         end else begin
            hold_last_d = 1'b1;
            hold_bn_d   = cnt_q[1:0];
            acc_last_d  = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_byte_packer.sv
// tb/tb_byte_packer.sv - directed self-checking bench for byte_packer
// Monitor logs every padder handoff; scenario tasks compare logs against hand-computed words.
module tb_byte_packer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   byte_packer_if ifc ();

   byte_packer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int gate_viol = 0;

   logic [7:0]  tb_bytes [0:15];
   logic [31:0] mon_w [$];
   logic        mon_l [$];
   logic [1:0]  mon_bn [$];
   int          mon_cyc [$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (ifc.pad_in_ready === 1'b1) begin
            mon_w.push_back(ifc.pad_in);
            mon_l.push_back(ifc.pad_is_last);
            mon_bn.push_back(ifc.pad_byte_num);
            mon_cyc.push_back(cyc);
         end
         if (ifc.pad_is_last === 1'b1 && ifc.pad_buffer_full === 1'b1) gate_viol++;
      end
   end

   task automatic clear_log();
      mon_w.delete();
      mon_l.delete();
      mon_bn.delete();
      mon_cyc.delete();
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      ifc.in_valid = 1'b0;
      ifc.in_last = 1'b0;
      ifc.in_byte = 8'h00;
      ifc.pad_buffer_full = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      clear_log();
   endtask

   task automatic drive_bytes(input int n, input bit set_last, input int full_cycles,
                              output int acc4_cyc);
      int idx = 0;
      int c = 0;
      acc4_cyc = -100;
      while (idx < n && c < 100) begin
         @(posedge clk); #1;
         ifc.pad_buffer_full = (c < full_cycles);
         ifc.in_valid = 1'b1;
         ifc.in_byte = tb_bytes[idx];
         ifc.in_last = set_last && (idx == n - 1);
         @(negedge clk);
         if (c < full_cycles) begin
            checks++;
            if (ifc.pad_in_ready !== 1'b0 || ifc.pad_is_last !== 1'b0) begin
               failures++;
               $display("FAIL bp_gate cycle=%0d pad_in_ready=%b pad_is_last=%b expected 0 0",
                        c, ifc.pad_in_ready, ifc.pad_is_last);
            end
         end
         if (ifc.in_ready === 1'b1) begin
            if (idx == 3) acc4_cyc = cyc;
            idx++;
         end
         if (full_cycles > 0 && c == full_cycles - 1) begin
            checks++;
            if (ifc.in_ready !== 1'b0 || idx != 8) begin
               failures++;
               $display("FAIL bp_stall in_ready=%b accepted=%0d expected 0 8", ifc.in_ready, idx);
            end
         end
         c++;
      end
      checks++;
      if (idx != n) begin
         failures++;
         $display("FAIL drive_timeout accepted=%0d expected %0d", idx, n);
      end
      @(posedge clk); #1;
      ifc.in_valid = 1'b0;
      ifc.in_last = 1'b0;
      ifc.pad_buffer_full = 1'b0;
   endtask

   task automatic wait_done();
      int c = 0;
      while (ifc.msg_done !== 1'b1 && c < 50) begin
         @(negedge clk);
         c++;
      end
      checks++;
      if (ifc.msg_done !== 1'b1) begin
         failures++;
         $display("FAIL msg_done_timeout msg_done=%b expected 1", ifc.msg_done);
      end
   endtask

   task automatic check_zero_state(input string tag);
      @(negedge clk);
      checks++;
      if (ifc.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s_in_ready got=%b expected 1", tag, ifc.in_ready);
      end
      checks++;
      if (ifc.pad_in !== 32'h0) begin
         failures++;
         $display("FAIL %s_pad_in got=%h expected 00000000", tag, ifc.pad_in);
      end
      checks++;
      if (ifc.pad_in_ready !== 1'b0 || ifc.pad_is_last !== 1'b0) begin
         failures++;
         $display("FAIL %s_pad_flags got=%b%b expected 00", tag, ifc.pad_in_ready, ifc.pad_is_last);
      end
      checks++;
      if (ifc.pad_byte_num !== 2'd0) begin
         failures++;
         $display("FAIL %s_byte_num got=%0d expected 0", tag, ifc.pad_byte_num);
      end
      checks++;
      if (ifc.msg_done !== 1'b0) begin
         failures++;
         $display("FAIL %s_msg_done got=%b expected 0", tag, ifc.msg_done);
      end
   endtask

   task automatic test_reset();
      do_reset();
      check_zero_state("reset");
   endtask

   task automatic test_five_bytes();
      int a4;
      do_reset();
      tb_bytes[0] = 8'h61; tb_bytes[1] = 8'h62; tb_bytes[2] = 8'h63;
      tb_bytes[3] = 8'h64; tb_bytes[4] = 8'h65;
      drive_bytes(5, 1'b1, 0, a4);
      wait_done();
      checks++;
      if (ifc.in_ready !== 1'b0) begin
         failures++;
         $display("FAIL five_in_ready_done got=%b expected 0", ifc.in_ready);
      end
      checks++;
      if (mon_w.size() != 2) begin
         failures++;
         $display("FAIL five_count got=%0d expected 2", mon_w.size());
      end else begin
         checks++;
         if (mon_w[0] !== 32'h61626364 || mon_l[0] !== 1'b0) begin
            failures++;
            $display("FAIL five_word0 got=%h last=%b expected 61626364 last=0", mon_w[0], mon_l[0]);
         end
         checks++;
         if (mon_w[1] !== 32'h65000000 || mon_l[1] !== 1'b1 || mon_bn[1] !== 2'd1) begin
            failures++;
            $display("FAIL five_word1 got=%h last=%b bn=%0d expected 65000000 last=1 bn=1",
                     mon_w[1], mon_l[1], mon_bn[1]);
         end
         checks++;
         if (mon_cyc[0] - a4 != 2) begin
            failures++;
            $display("FAIL five_latency got=%0d expected 2", mon_cyc[0] - a4);
         end
      end
   endtask

   task automatic test_four_bytes();
      int a4;
      do_reset();
      tb_bytes[0] = 8'h01; tb_bytes[1] = 8'h02; tb_bytes[2] = 8'h03; tb_bytes[3] = 8'h04;
      drive_bytes(4, 1'b1, 0, a4);
      wait_done();
      repeat (3) @(negedge clk);
      checks++;
      if (mon_w.size() != 2) begin
         failures++;
         $display("FAIL four_count got=%0d expected 2", mon_w.size());
      end else begin
         checks++;
         if (mon_w[0] !== 32'h01020304 || mon_l[0] !== 1'b0) begin
            failures++;
            $display("FAIL four_word0 got=%h last=%b expected 01020304 last=0", mon_w[0], mon_l[0]);
         end
         checks++;
         if (mon_w[1] !== 32'h0 || mon_l[1] !== 1'b1 || mon_bn[1] !== 2'd0) begin
            failures++;
            $display("FAIL four_word1 got=%h last=%b bn=%0d expected 00000000 last=1 bn=0",
                     mon_w[1], mon_l[1], mon_bn[1]);
         end
      end
   endtask

   task automatic test_single_byte();
      int a4;
      do_reset();
      tb_bytes[0] = 8'hAA;
      drive_bytes(1, 1'b1, 0, a4);
      wait_done();
      checks++;
      if (mon_w.size() != 1) begin
         failures++;
         $display("FAIL single_count got=%0d expected 1", mon_w.size());
      end else begin
         checks++;
         if (mon_w[0] !== 32'hAA000000 || mon_l[0] !== 1'b1 || mon_bn[0] !== 2'd1) begin
            failures++;
            $display("FAIL single_word got=%h last=%b bn=%0d expected AA000000 last=1 bn=1",
                     mon_w[0], mon_l[0], mon_bn[0]);
         end
      end
   endtask

   task automatic test_backpressure();
      int a4;
      do_reset();
      for (int i = 0; i < 9; i++) tb_bytes[i] = 8'h11 + 8'(i);
      drive_bytes(9, 1'b1, 20, a4);
      wait_done();
      checks++;
      if (mon_w.size() != 3) begin
         failures++;
         $display("FAIL bp_count got=%0d expected 3", mon_w.size());
      end else begin
         checks++;
         if (mon_w[0] !== 32'h11121314 || mon_l[0] !== 1'b0) begin
            failures++;
            $display("FAIL bp_word0 got=%h last=%b expected 11121314 last=0", mon_w[0], mon_l[0]);
         end
         checks++;
         if (mon_w[1] !== 32'h15161718 || mon_l[1] !== 1'b0) begin
            failures++;
            $display("FAIL bp_word1 got=%h last=%b expected 15161718 last=0", mon_w[1], mon_l[1]);
         end
         checks++;
         if (mon_w[2] !== 32'h19000000 || mon_l[2] !== 1'b1 || mon_bn[2] !== 2'd1) begin
            failures++;
            $display("FAIL bp_word2 got=%h last=%b bn=%0d expected 19000000 last=1 bn=1",
                     mon_w[2], mon_l[2], mon_bn[2]);
         end
      end
   endtask

   task automatic test_mid_reset();
      int a4;
      do_reset();
      for (int i = 0; i < 6; i++) tb_bytes[i] = 8'h20 + 8'(i);
      drive_bytes(6, 1'b0, 0, a4);
      do_reset();
      check_zero_state("midrst");
      tb_bytes[0] = 8'hAB; tb_bytes[1] = 8'hCD; tb_bytes[2] = 8'hEF;
      drive_bytes(3, 1'b1, 0, a4);
      wait_done();
      checks++;
      if (mon_w.size() != 1) begin
         failures++;
         $display("FAIL midrst_count got=%0d expected 1", mon_w.size());
      end else begin
         checks++;
         if (mon_w[0] !== 32'hABCDEF00 || mon_l[0] !== 1'b1 || mon_bn[0] !== 2'd3) begin
            failures++;
            $display("FAIL midrst_word got=%h last=%b bn=%0d expected ABCDEF00 last=1 bn=3",
                     mon_w[0], mon_l[0], mon_bn[0]);
         end
      end
   endtask

   task automatic test_after_done();
      int n0 = mon_w.size();
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         ifc.in_valid = 1'b1;
         ifc.in_byte = 8'h5A + 8'(i);
         ifc.in_last = (i == 9);
         @(negedge clk);
         checks++;
         if (ifc.in_ready !== 1'b0 || ifc.pad_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL done_idle cycle=%0d in_ready=%b pad_in_ready=%b expected 0 0",
                     i, ifc.in_ready, ifc.pad_in_ready);
         end
      end
      @(posedge clk); #1;
      ifc.in_valid = 1'b0;
      ifc.in_last = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (mon_w.size() != n0 || ifc.msg_done !== 1'b1) begin
         failures++;
         $display("FAIL done_no_handoff count=%0d msg_done=%b expected %0d 1",
                  mon_w.size(), ifc.msg_done, n0);
      end
   endtask

   task automatic test_gating();
      checks++;
      if (gate_viol != 0) begin
         failures++;
         $display("FAIL is_last_gating violations=%0d expected 0", gate_viol);
      end
   endtask

   initial begin
      ifc.in_valid = 1'b0;
      ifc.in_last = 1'b0;
      ifc.in_byte = 8'h00;
      ifc.pad_buffer_full = 1'b0;
      test_reset();
      test_five_bytes();
      test_four_bytes();
      test_single_byte();
      test_backpressure();
      test_mid_reset();
      test_after_done();
      test_gating();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
